// File: rtl/dev_bridge.sv
// CPU-to-peripheral bridge: decodes CPU accesses into 4-word device register
// accesses with a registered ack/err response, and masks peripheral interrupts.
module dev_bridge #(
   parameter logic [31:0] DEV0_BASE = 32'h0000_7F00,
   parameter logic [31:0] DEV1_BASE = 32'h0000_7F10,
   parameter logic [31:0] BRG_BASE  = 32'h0000_7F20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_ack,
   output logic        cpu_err,
   output logic [1:0]  dev_addr,
   output logic [31:0] dev_wdata,
   output logic        dev0_we,
   output logic        dev1_we,
   input  logic [31:0] dev0_rdata,
   input  logic [31:0] dev1_rdata,
   input  logic [1:0]  irq_in,
   output logic [1:0]  hwint
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   typedef enum logic [1:0] {SEL_NONE, SEL_DEV0, SEL_DEV1, SEL_BRG} sel_t;

   state_t      state;
   sel_t        sel_d;
   sel_t        sel_q;
   logic        bad_d;
   logic        we_q;
   logic [1:0]  mask;
   logic [31:0] brg_rdata;

   always_comb begin
      sel_d = SEL_NONE;
      if (cpu_addr[31:4] == DEV0_BASE[31:4])
         sel_d = SEL_DEV0;
      else if (cpu_addr[31:4] == DEV1_BASE[31:4])
         sel_d = SEL_DEV1;
      else if (cpu_addr[31:4] == BRG_BASE[31:4])
         sel_d = SEL_BRG;
      bad_d = (cpu_addr[1:0] != 2'b00) || (sel_d == SEL_NONE);
   end

   always_comb begin
      brg_rdata = '0;
      case (dev_addr)
         2'd0:    brg_rdata = {30'd0, mask};
         2'd1:    brg_rdata = {30'd0, irq_in};
         default: brg_rdata = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         sel_q     <= SEL_NONE;
         we_q      <= 1'b0;
         cpu_ack   <= 1'b0;
         cpu_err   <= 1'b0;
         cpu_rdata <= '0;
         dev0_we   <= 1'b0;
         dev1_we   <= 1'b0;
         dev_addr  <= '0;
         dev_wdata <= '0;
         mask      <= 2'b11;
         hwint     <= '0;
      end else begin
         hwint   <= irq_in & mask;
         cpu_ack <= 1'b0;
         dev0_we <= 1'b0;
         dev1_we <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_req) begin
                  we_q      <= cpu_we;
                  dev_addr  <= cpu_addr[3:2];
                  dev_wdata <= cpu_wdata;
                  sel_q     <= sel_d;
                  cpu_err   <= bad_d;
                  if (bad_d) begin
                     // Errors skip ACCESS entirely, so no strobe can be issued.
                     state     <= RESP;
                     cpu_ack   <= 1'b1;
                     cpu_rdata <= '0;
                  end else begin
                     state   <= ACCESS;
                     dev0_we <= cpu_we && (sel_d == SEL_DEV0);
                     dev1_we <= cpu_we && (sel_d == SEL_DEV1);
                  end
               end
            end
            ACCESS: begin
               state   <= RESP;
               cpu_ack <= 1'b1;
               if (we_q) begin
                  cpu_rdata <= '0;
                  if (sel_q == SEL_BRG && dev_addr == 2'd0)
                     mask <= dev_wdata[1:0];
               end else begin
                  case (sel_q)
                     SEL_DEV0: cpu_rdata <= dev0_rdata;
                     SEL_DEV1: cpu_rdata <= dev1_rdata;
                     SEL_BRG:  cpu_rdata <= brg_rdata;
                     default:  cpu_rdata <= '0;
                  endcase
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
